data_ram_win_ctrl: RTL

//  Sequencer for the 19-byte shift-window data RAM (write enable shifts din into the top, oldest byte out
//  the bottom). Streams one row of input bytes into the RAM, fills the first window, then slides it by

---
 rtl/data_ram_win_ctrl_if.sv | 34 +++
 rtl/data_ram_win_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/data_ram_win_ctrl_if.sv
// Bus between the input byte stream / downstream MAC stage and the shift-window
// RAM sequencer. The slave side is the controller; the master side drives it.
interface data_ram_win_ctrl_if #(
    parameter int DW    = 8,
    parameter int LEN_W = 16
);
    // Handshakes: a sample moves when in_valid && in_ready on a rising clk edge;
    // a window is consumed when win_valid && win_ready. Valid never waits on
    // ready, and a presented window stays put until it is consumed.
    logic             start;
    logic [LEN_W-1:0] row_len;
    logic [3:0]       stride;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             ram_wen;
    logic [DW-1:0]    ram_din;
    logic             win_valid;
    logic             win_ready;
    logic [LEN_W-1:0] win_cnt;
    logic             busy;
    logic             done;
    logic [2:0]       dbg_state;

    modport master (
        output start, row_len, stride, in_valid, in_data, win_ready,
        input  in_ready, ram_wen, ram_din, win_valid, win_cnt, busy, done, dbg_state
    );

    modport slave (
        input  start, row_len, stride, in_valid, in_data, win_ready,
        output in_ready, ram_wen, ram_din, win_valid, win_cnt, busy, done, dbg_state
    );
endinterface

// File: rtl/data_ram_win_ctrl.sv
// Sequencer for the shift-window data RAM: fills the first WIN-byte window of a
// row, then slides it by stride per window and presents each stable window.
module data_ram_win_ctrl #(
    parameter int WIN   = 19,
    parameter int DW    = 8,
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    data_ram_win_ctrl_if.slave bus
);
    localparam int PH_W = ($clog2(WIN + 1) > 4) ? $clog2(WIN + 1) : 4;
    localparam logic [PH_W-1:0] PH_WIN_LAST = PH_W'(WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WAIT  = 3'd2,
        S_SLIDE = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state, state_d;
    logic [LEN_W-1:0] row_len_q, row_len_d;
    logic [LEN_W-1:0] consumed, consumed_d;
    logic [LEN_W-1:0] win_cnt_q, win_cnt_d;
    logic [3:0]       stride_q, stride_d;
    logic [PH_W-1:0]  phase, phase_d;

    logic             fill_or_slide;
    logic             acc;
    logic [LEN_W-1:0] consumed_inc;
    logic [LEN_W:0]   next_end;
    logic [PH_W-1:0]  stride_last;
    logic [PH_W-1:0]  last_phase;

    assign fill_or_slide = (state == S_FILL) || (state == S_SLIDE);
    assign acc           = bus.in_valid && bus.in_ready;
    assign consumed_inc  = consumed + LEN_W'(1);
    // One bit wider so that consumed + stride near 2^LEN_W-1 cannot wrap.
    assign next_end      = {1'b0, consumed} + (LEN_W + 1)'(stride_q);
    assign stride_last   = PH_W'(stride_q) - PH_W'(1);
    assign last_phase    = (state == S_FILL) ? PH_WIN_LAST : stride_last;

    assign bus.in_ready  = fill_or_slide || (state == S_DRAIN);
    assign bus.ram_wen   = acc && fill_or_slide;
    assign bus.ram_din   = bus.ram_wen ? bus.in_data : '0;
    assign bus.win_valid = (state == S_WAIT);
    assign bus.win_cnt   = win_cnt_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            row_len_q <= '0;
            consumed  <= '0;
            win_cnt_q <= '0;
            stride_q  <= '0;
            phase     <= '0;
        end else begin
            state     <= state_d;
            row_len_q <= row_len_d;
            consumed  <= consumed_d;
            win_cnt_q <= win_cnt_d;
            stride_q  <= stride_d;
            phase     <= phase_d;
        end
    end

    always_comb begin
        state_d    = state;
        row_len_d  = row_len_q;
        consumed_d = consumed;
        win_cnt_d  = win_cnt_q;
        stride_d   = stride_q;
        phase_d    = phase;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    row_len_d  = bus.row_len;
                    stride_d   = (bus.stride == 4'd0) ? 4'd1 : bus.stride;
                    consumed_d = '0;
                    win_cnt_d  = '0;
                    phase_d    = '0;
                    // A row shorter than one window produces nothing.
                    state_d    = (bus.row_len >= LEN_W'(WIN)) ? S_FILL : S_DONE;
                end
            end

            S_FILL, S_SLIDE: begin
                if (acc) begin
                    consumed_d = consumed_inc;
                    if (phase == last_phase) begin
                        phase_d = '0;
                        state_d = S_WAIT;
                    end else begin
                        phase_d = phase + PH_W'(1);
                    end
                end
            end

            S_WAIT: begin
                if (bus.win_ready) begin
                    win_cnt_d = win_cnt_q + LEN_W'(1);
                    if (next_end <= {1'b0, row_len_q}) begin
                        state_d = S_SLIDE;
                    end else if (consumed < row_len_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DRAIN: begin
                // Tail samples that cannot complete another window are swallowed.
                if (acc) begin
                    consumed_d = consumed_inc;
                    if (consumed_inc == row_len_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
